// File: rtl/m_port_par_if.sv
// Parallel master-side and serial bus-side signals of the m_port_par master port.
// The master modport is the port's view; the slave modport is the surrounding system's view.
interface m_port_par_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 1
);
    // parallel master interface
    logic                  m_start;
    logic                  m_rw;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [DATA_WIDTH-1:0] m_wdata;
    logic                  m_busy;
    logic [DATA_WIDTH-1:0] m_rdata;
    logic                  m_rdata_valid;
    logic                  m_ack;
    logic                  m_err;
    logic                  m_split;

    // arbitration
    logic                  arb_req;
    logic                  arb_grant;

    // serial bus
    logic [LANES-1:0]      bus_tx;
    logic                  bus_tx_valid;
    logic                  bus_mode;
    logic                  bus_rw;
    logic [LANES-1:0]      bus_rx;
    logic                  bus_rx_valid;
    logic                  s_ack;
    logic                  s_split;

    modport master (
        input  m_start, m_rw, m_addr, m_wdata,
        output m_busy, m_rdata, m_rdata_valid, m_ack, m_err, m_split,
        output arb_req,
        input  arb_grant,
        output bus_tx, bus_tx_valid, bus_mode, bus_rw,
        input  bus_rx, bus_rx_valid, s_ack, s_split
    );

    modport slave (
        output m_start, m_rw, m_addr, m_wdata,
        input  m_busy, m_rdata, m_rdata_valid, m_ack, m_err, m_split,
        input  arb_req,
        output arb_grant,
        input  bus_tx, bus_tx_valid, bus_mode, bus_rw,
        output bus_rx, bus_rx_valid, s_ack, s_split
    );
endinterface

// File: rtl/m_port_par.sv
// Next-generation serial bus master port: arbitration, multi-lane LSB-first
// serialisation of address/write data, read deserialisation, split suspension,
// grant-loss restart and completion timeout. All outputs are registered.
module m_port_par #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 1,
    parameter int TIMEOUT    = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    m_port_par_if.master mp
);
    localparam int AB   = ADDR_WIDTH / LANES;
    localparam int DB   = DATA_WIDTH / LANES;
    localparam int BMAX = (AB > DB) ? AB : DB;
    localparam int CW   = $clog2(BMAX + 1);
    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CW-1:0] AB_N     = CW'(AB);
    localparam logic [CW-1:0] DB_N     = CW'(DB);
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_WDATA = 3'd3;
    localparam logic [2:0] S_WACK  = 3'd4;
    localparam logic [2:0] S_RDATA = 3'd5;
    localparam logic [2:0] S_SPLIT = 3'd6;

    logic [2:0]            state;
    logic                  rw_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         rx_cnt;
    logic                  ack_seen;
    logic [TW-1:0]         tmo_cnt;

    logic                  busy_q;
    logic [DATA_WIDTH-1:0] m_rdata_q;
    logic                  rvalid_q;
    logic                  ack_q;
    logic                  err_q;
    logic                  split_q;
    logic                  arb_req_q;
    logic [LANES-1:0]      tx_q;
    logic                  tx_valid_q;
    logic                  mode_q;
    logic                  bus_rw_q;

    // read-side next values: beat insertion, completion, progress and timeout detection
    logic [DATA_WIDTH-1:0] rx_ins;
    logic [CW-1:0]         rx_cnt_nx;
    logic                  rd_done;
    logic                  progress;
    logic                  tmo_hit;

    // Completion must see a beat arriving in the same cycle as s_ack, so the
    // insertion is computed combinationally and committed on the completion edge.
    always_comb begin
        rx_ins    = rdata_q;
        rx_cnt_nx = rx_cnt;
        if (mp.bus_rx_valid && (rx_cnt < DB_N)) begin
            rx_ins[int'(rx_cnt) * LANES +: LANES] = mp.bus_rx;
            rx_cnt_nx = rx_cnt + CW'(1);
        end
        rd_done  = (rx_cnt_nx == DB_N) && (ack_seen || mp.s_ack);
        progress = mp.bus_rx_valid || mp.s_ack;
        tmo_hit  = (TIMEOUT > 0) && !progress && (tmo_cnt == TMO_LAST);
    end

    // transaction sequencer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            cnt        <= '0;
            rx_cnt     <= '0;
            ack_seen   <= 1'b0;
            tmo_cnt    <= '0;
            busy_q     <= 1'b0;
            m_rdata_q  <= '0;
            rvalid_q   <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            split_q    <= 1'b0;
            arb_req_q  <= 1'b0;
            tx_q       <= '0;
            tx_valid_q <= 1'b0;
            mode_q     <= 1'b0;
            bus_rw_q   <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (mp.m_start) begin
                        rw_q      <= mp.m_rw;
                        addr_q    <= mp.m_addr;
                        wdata_q   <= mp.m_wdata;
                        rdata_q   <= '0;
                        cnt       <= '0;
                        rx_cnt    <= '0;
                        ack_seen  <= 1'b0;
                        tmo_cnt   <= '0;
                        busy_q    <= 1'b1;
                        bus_rw_q  <= mp.m_rw;
                        arb_req_q <= 1'b1;
                        mode_q    <= 1'b0;
                        state     <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (mp.arb_grant) begin
                        tx_q       <= addr_q[LANES-1:0];
                        tx_valid_q <= 1'b1;
                        mode_q     <= 1'b0;
                        cnt        <= CW'(1);
                        state      <= S_ADDR;
                    end
                end

                S_ADDR: begin
                    if (!mp.arb_grant) begin
                        tx_q       <= '0;
                        tx_valid_q <= 1'b0;
                        mode_q     <= 1'b0;
                        cnt        <= '0;
                        state      <= S_REQ;
                    end else if (cnt < AB_N) begin
                        tx_q <= addr_q[int'(cnt) * LANES +: LANES];
                        cnt  <= cnt + CW'(1);
                    end else if (rw_q) begin
                        tx_q   <= wdata_q[LANES-1:0];
                        mode_q <= 1'b1;
                        cnt    <= CW'(1);
                        state  <= S_WDATA;
                    end else begin
                        tx_q       <= '0;
                        tx_valid_q <= 1'b0;
                        mode_q     <= 1'b1;
                        arb_req_q  <= 1'b0;
                        tmo_cnt    <= '0;
                        state      <= S_RDATA;
                    end
                end

                S_WDATA: begin
                    if (!mp.arb_grant) begin
                        tx_q       <= '0;
                        tx_valid_q <= 1'b0;
                        mode_q     <= 1'b0;
                        cnt        <= '0;
                        state      <= S_REQ;
                    end else if (cnt < DB_N) begin
                        tx_q <= wdata_q[int'(cnt) * LANES +: LANES];
                        cnt  <= cnt + CW'(1);
                    end else begin
                        tx_q       <= '0;
                        tx_valid_q <= 1'b0;
                        arb_req_q  <= 1'b0;
                        tmo_cnt    <= '0;
                        state      <= S_WACK;
                    end
                end

                S_WACK: begin
                    if (mp.s_ack) begin
                        ack_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        bus_rw_q <= 1'b0;
                        mode_q   <= 1'b0;
                        state    <= S_IDLE;
                    end else if (tmo_hit) begin
                        err_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        bus_rw_q <= 1'b0;
                        mode_q   <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        tmo_cnt <= progress ? '0 : tmo_cnt + TW'(1);
                    end
                end

                S_RDATA: begin
                    rdata_q <= rx_ins;
                    rx_cnt  <= rx_cnt_nx;
                    if (mp.s_ack) ack_seen <= 1'b1;
                    if (rd_done) begin
                        m_rdata_q <= rx_ins;
                        rvalid_q  <= 1'b1;
                        ack_q     <= 1'b1;
                        busy_q    <= 1'b0;
                        bus_rw_q  <= 1'b0;
                        mode_q    <= 1'b0;
                        state     <= S_IDLE;
                    end else if (mp.s_split && (rx_cnt == '0) && !mp.bus_rx_valid) begin
                        split_q <= 1'b1;
                        state   <= S_SPLIT;
                    end else if (tmo_hit) begin
                        err_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        bus_rw_q <= 1'b0;
                        mode_q   <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        tmo_cnt <= progress ? '0 : tmo_cnt + TW'(1);
                    end
                end

                S_SPLIT: begin
                    rdata_q <= rx_ins;
                    rx_cnt  <= rx_cnt_nx;
                    if (mp.s_ack) ack_seen <= 1'b1;
                    if (mp.bus_rx_valid) begin
                        split_q <= 1'b0;
                        tmo_cnt <= '0;
                        if (rd_done) begin
                            m_rdata_q <= rx_ins;
                            rvalid_q  <= 1'b1;
                            ack_q     <= 1'b1;
                            busy_q    <= 1'b0;
                            bus_rw_q  <= 1'b0;
                            mode_q    <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            state <= S_RDATA;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign mp.m_busy        = busy_q;
    assign mp.m_rdata       = m_rdata_q;
    assign mp.m_rdata_valid = rvalid_q;
    assign mp.m_ack         = ack_q;
    assign mp.m_err         = err_q;
    assign mp.m_split       = split_q;
    assign mp.arb_req       = arb_req_q;
    assign mp.bus_tx        = tx_q;
    assign mp.bus_tx_valid  = tx_valid_q;
    assign mp.bus_mode      = mode_q;
    assign mp.bus_rw        = bus_rw_q;
endmodule
